// File: rtl/axi_slave_ram.sv
`timescale 1ns/1ps
// AXI4 slave backed by an on-chip RAM: INCR bursts, one outstanding write and one outstanding read.
// Responses echo the request ID so the interconnect can route them back to the issuing master.
module axi_slave_ram #(
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ID_WIDTH-1:0]     WR_ADDR_ID,
    input  logic [31:0]             WR_ADDR,
    input  logic [7:0]              WR_ADDR_LEN,
    input  logic                    WR_ADDR_VALID,
    output logic                    WR_ADDR_READY,
    input  logic [DATA_WIDTH-1:0]   WR_DATA,
    input  logic [DATA_WIDTH/8-1:0] WR_DATA_STRB,
    input  logic                    WR_DATA_LAST,
    input  logic                    WR_DATA_VALID,
    output logic                    WR_DATA_READY,
    output logic [ID_WIDTH-1:0]     WR_BACK_ID,
    output logic [1:0]              WR_BACK_RESP,
    output logic                    WR_BACK_VALID,
    input  logic                    WR_BACK_READY,
    input  logic [ID_WIDTH-1:0]     RD_ADDR_ID,
    input  logic [31:0]             RD_ADDR,
    input  logic [7:0]              RD_ADDR_LEN,
    input  logic                    RD_ADDR_VALID,
    output logic                    RD_ADDR_READY,
    output logic [ID_WIDTH-1:0]     RD_BACK_ID,
    output logic [DATA_WIDTH-1:0]   RD_DATA,
    output logic [1:0]              RD_DATA_RESP,
    output logic                    RD_DATA_LAST,
    output logic                    RD_DATA_VALID,
    input  logic                    RD_DATA_READY
);

    localparam int unsigned STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned BYTE_LOG2 = $clog2(STRB_W);
    localparam int unsigned IDX_W     = MEM_DEPTH_LOG2;
    localparam int unsigned DEPTH     = 2 ** MEM_DEPTH_LOG2;
    localparam int unsigned CNT_W     = 9;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> BYTE_LOG2);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;

    logic [1:0]          w_state, w_state_n;
    logic [ID_WIDTH-1:0] w_id, w_id_n;
    logic [IDX_W-1:0]    w_idx, w_idx_n;
    logic [7:0]          w_len, w_len_n;
    logic [CNT_W-1:0]    w_cnt, w_cnt_n;
    logic                b_valid_n;
    logic [ID_WIDTH-1:0] b_id_n;
    logic [1:0]          b_resp_n;
    logic                mem_we;

    // Write FSM next state; the beat counter saturates so overlong bursts never alias back into range.
    always_comb begin
        w_state_n = w_state;
        w_id_n    = w_id;
        w_idx_n   = w_idx;
        w_len_n   = w_len;
        w_cnt_n   = w_cnt;
        b_valid_n = WR_BACK_VALID;
        b_id_n    = WR_BACK_ID;
        b_resp_n  = WR_BACK_RESP;
        mem_we    = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (WR_ADDR_VALID && WR_ADDR_READY) begin
                    w_state_n = W_DATA;
                    w_id_n    = WR_ADDR_ID;
                    w_idx_n   = word_idx(WR_ADDR);
                    w_len_n   = WR_ADDR_LEN;
                    w_cnt_n   = '0;
                end
            end
            W_DATA: begin
                if (WR_DATA_VALID && WR_DATA_READY) begin
                    mem_we  = (w_cnt <= {1'b0, w_len});
                    w_idx_n = w_idx + IDX_W'(1);
                    if (!w_cnt[CNT_W-1]) w_cnt_n = w_cnt + CNT_W'(1);
                    if (WR_DATA_LAST) begin
                        w_state_n = W_RESP;
                        b_valid_n = 1'b1;
                        b_id_n    = w_id;
                        b_resp_n  = (w_cnt == {1'b0, w_len}) ? 2'b00 : 2'b10;
                    end
                end
            end
            W_RESP: begin
                if (WR_BACK_VALID && WR_BACK_READY) begin
                    w_state_n = W_IDLE;
                    b_valid_n = 1'b0;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state       <= W_IDLE;
            w_id          <= '0;
            w_idx         <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            WR_ADDR_READY <= 1'b0;
            WR_DATA_READY <= 1'b0;
            WR_BACK_VALID <= 1'b0;
            WR_BACK_ID    <= '0;
            WR_BACK_RESP  <= 2'b00;
        end else begin
            w_state       <= w_state_n;
            w_id          <= w_id_n;
            w_idx         <= w_idx_n;
            w_len         <= w_len_n;
            w_cnt         <= w_cnt_n;
            WR_ADDR_READY <= (w_state_n == W_IDLE);
            WR_DATA_READY <= (w_state_n == W_DATA);
            WR_BACK_VALID <= b_valid_n;
            WR_BACK_ID    <= b_id_n;
            WR_BACK_RESP  <= b_resp_n;
        end
    end

    logic [0:0]          r_state, r_state_n;
    logic [ID_WIDTH-1:0] r_id_n;
    logic [IDX_W-1:0]    r_idx, r_idx_n;
    logic [7:0]          r_len, r_len_n;
    logic [CNT_W-1:0]    r_iss, r_iss_n;
    logic                q_valid, q_valid_n;
    logic                q_last, q_last_n;
    logic                r_hs, out_load, rd_issue;
    logic                rvalid_n, rlast_n;
    logic [DATA_WIDTH-1:0] rdata_n;

    // Two-stage read pipe (RAM register, then output register); a RAM read is issued only when its slot is free.
    always_comb begin
        r_hs      = RD_DATA_VALID && RD_DATA_READY;
        out_load  = q_valid && (!RD_DATA_VALID || r_hs);
        rd_issue  = (r_state == R_DATA) && (r_iss <= {1'b0, r_len}) && (!q_valid || out_load);
        r_state_n = r_state;
        r_id_n    = RD_BACK_ID;
        r_idx_n   = r_idx;
        r_len_n   = r_len;
        r_iss_n   = r_iss;
        case (r_state)
            R_IDLE: begin
                if (RD_ADDR_VALID && RD_ADDR_READY) begin
                    r_state_n = R_DATA;
                    r_id_n    = RD_ADDR_ID;
                    r_idx_n   = word_idx(RD_ADDR);
                    r_len_n   = RD_ADDR_LEN;
                    r_iss_n   = '0;
                end
            end
            R_DATA: begin
                if (rd_issue) begin
                    r_idx_n = r_idx + IDX_W'(1);
                    r_iss_n = r_iss + CNT_W'(1);
                end
                if (r_hs && RD_DATA_LAST) r_state_n = R_IDLE;
            end
            default: r_state_n = R_IDLE;
        endcase
        q_valid_n = rd_issue ? 1'b1 : (out_load ? 1'b0 : q_valid);
        q_last_n  = rd_issue ? (r_iss == {1'b0, r_len}) : q_last;
        rvalid_n  = out_load ? 1'b1 : (r_hs ? 1'b0 : RD_DATA_VALID);
        rlast_n   = out_load ? q_last : (r_hs ? 1'b0 : RD_DATA_LAST);
        rdata_n   = out_load ? ram_q : RD_DATA;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= R_IDLE;
            r_idx         <= '0;
            r_len         <= '0;
            r_iss         <= '0;
            q_valid       <= 1'b0;
            q_last        <= 1'b0;
            RD_ADDR_READY <= 1'b0;
            RD_BACK_ID    <= '0;
            RD_DATA       <= '0;
            RD_DATA_LAST  <= 1'b0;
            RD_DATA_VALID <= 1'b0;
        end else begin
            r_state       <= r_state_n;
            r_idx         <= r_idx_n;
            r_len         <= r_len_n;
            r_iss         <= r_iss_n;
            q_valid       <= q_valid_n;
            q_last        <= q_last_n;
            RD_ADDR_READY <= (r_state_n == R_IDLE);
            RD_BACK_ID    <= r_id_n;
            RD_DATA       <= rdata_n;
            RD_DATA_LAST  <= rlast_n;
            RD_DATA_VALID <= rvalid_n;
        end
    end

    assign RD_DATA_RESP = 2'b00;

    // Both ports sample the array on the same edge, so a colliding read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WR_DATA_STRB[b]) mem[w_idx][b*8 +: 8] <= WR_DATA[b*8 +: 8];
            end
        end
        if (rd_issue) ram_q <= mem[r_idx];
    end

endmodule

// File: tb/tb_axi_slave_ram.sv
`timescale 1ns/1ps
// Directed bench for axi_slave_ram: bursts, strobes, LAST errors, R stalls, wrap, collision and reset.
module tb_axi_slave_ram;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  WR_ADDR_ID;
    logic [31:0] WR_ADDR;
    logic [7:0]  WR_ADDR_LEN;
    logic        WR_ADDR_VALID;
    logic        WR_ADDR_READY;
    logic [31:0] WR_DATA;
    logic [3:0]  WR_DATA_STRB;
    logic        WR_DATA_LAST;
    logic        WR_DATA_VALID;
    logic        WR_DATA_READY;
    logic [3:0]  WR_BACK_ID;
    logic [1:0]  WR_BACK_RESP;
    logic        WR_BACK_VALID;
    logic        WR_BACK_READY;
    logic [3:0]  RD_ADDR_ID;
    logic [31:0] RD_ADDR;
    logic [7:0]  RD_ADDR_LEN;
    logic        RD_ADDR_VALID;
    logic        RD_ADDR_READY;
    logic [3:0]  RD_BACK_ID;
    logic [31:0] RD_DATA;
    logic [1:0]  RD_DATA_RESP;
    logic        RD_DATA_LAST;
    logic        RD_DATA_VALID;
    logic        RD_DATA_READY;

    axi_slave_ram #(.ID_WIDTH(4), .DATA_WIDTH(32), .MEM_DEPTH_LOG2(10), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rstn(rstn),
        .WR_ADDR_ID(WR_ADDR_ID), .WR_ADDR(WR_ADDR), .WR_ADDR_LEN(WR_ADDR_LEN),
        .WR_ADDR_VALID(WR_ADDR_VALID), .WR_ADDR_READY(WR_ADDR_READY),
        .WR_DATA(WR_DATA), .WR_DATA_STRB(WR_DATA_STRB), .WR_DATA_LAST(WR_DATA_LAST),
        .WR_DATA_VALID(WR_DATA_VALID), .WR_DATA_READY(WR_DATA_READY),
        .WR_BACK_ID(WR_BACK_ID), .WR_BACK_RESP(WR_BACK_RESP),
        .WR_BACK_VALID(WR_BACK_VALID), .WR_BACK_READY(WR_BACK_READY),
        .RD_ADDR_ID(RD_ADDR_ID), .RD_ADDR(RD_ADDR), .RD_ADDR_LEN(RD_ADDR_LEN),
        .RD_ADDR_VALID(RD_ADDR_VALID), .RD_ADDR_READY(RD_ADDR_READY),
        .RD_BACK_ID(RD_BACK_ID), .RD_DATA(RD_DATA), .RD_DATA_RESP(RD_DATA_RESP),
        .RD_DATA_LAST(RD_DATA_LAST), .RD_DATA_VALID(RD_DATA_VALID), .RD_DATA_READY(RD_DATA_READY)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] r_data_q [16];
    logic        r_last_q [16];
    logic [3:0]  r_id_q;
    int          r_hold_err;
    int          r_beats;

    task automatic idle_inputs();
        WR_ADDR_ID = '0; WR_ADDR = '0; WR_ADDR_LEN = '0; WR_ADDR_VALID = 1'b0;
        WR_DATA = '0; WR_DATA_STRB = '0; WR_DATA_LAST = 1'b0; WR_DATA_VALID = 1'b0;
        WR_BACK_READY = 1'b0;
        RD_ADDR_ID = '0; RD_ADDR = '0; RD_ADDR_LEN = '0; RD_ADDR_VALID = 1'b0;
        RD_DATA_READY = 1'b0;
    endtask

    // Bus drivers: entered and left 1ns after a rising edge.
    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int cyc = 0;
        WR_ADDR_ID = id; WR_ADDR = addr; WR_ADDR_LEN = len; WR_ADDR_VALID = 1'b1;
        while (WR_ADDR_READY !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        if (cyc >= 50) begin n_checks++; n_fail++; $display("FAIL aw_timeout: READY never seen"); end
        @(posedge clk); #1;
        WR_ADDR_VALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int cyc = 0;
        WR_DATA = data; WR_DATA_STRB = strb; WR_DATA_LAST = last; WR_DATA_VALID = 1'b1;
        while (WR_DATA_READY !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        if (cyc >= 50) begin n_checks++; n_fail++; $display("FAIL w_timeout: READY never seen"); end
        @(posedge clk); #1;
        WR_DATA_VALID = 1'b0; WR_DATA_LAST = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int cyc = 0;
        RD_ADDR_ID = id; RD_ADDR = addr; RD_ADDR_LEN = len; RD_ADDR_VALID = 1'b1;
        while (RD_ADDR_READY !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        if (cyc >= 50) begin n_checks++; n_fail++; $display("FAIL ar_timeout: READY never seen"); end
        @(posedge clk); #1;
        RD_ADDR_VALID = 1'b0;
    endtask

    task automatic b_recv(output logic [3:0] id, output logic [1:0] resp);
        int cyc = 0;
        WR_BACK_READY = 1'b1;
        while (WR_BACK_VALID !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        if (cyc >= 50) begin n_checks++; n_fail++; $display("FAIL b_timeout: VALID never seen"); end
        id = WR_BACK_ID; resp = WR_BACK_RESP;
        @(posedge clk); #1;
        WR_BACK_READY = 1'b0;
    endtask

    task automatic r_collect(input int len, input bit toggle);
        int cyc = 0;
        int k = 0;
        bit stalled = 1'b0;
        logic [31:0] prev = '0;
        r_hold_err = 0;
        while (k <= len && cyc < 200) begin
            RD_DATA_READY = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (stalled && RD_DATA !== prev) r_hold_err++;
            stalled = 1'b0;
            if (RD_DATA_VALID === 1'b1) begin
                if (RD_DATA_READY) begin
                    r_data_q[k] = RD_DATA; r_last_q[k] = RD_DATA_LAST; r_id_q = RD_BACK_ID; k++;
                end else begin
                    stalled = 1'b1; prev = RD_DATA;
                end
            end
            @(posedge clk); #1; cyc++;
        end
        RD_DATA_READY = 1'b0;
        r_beats = k;
        if (cyc >= 200) begin n_checks++; n_fail++; $display("FAIL r_timeout: got %0d beats", k); end
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        idle_inputs();
        rstn = 1'b0;
        #2;
        outs = {WR_ADDR_READY, WR_DATA_READY, WR_BACK_VALID, RD_ADDR_READY, RD_DATA_VALID,
                RD_DATA_LAST, 26'(0)};
        n_checks++;
        if (outs !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h required 0", outs); end
        n_checks++;
        if ({WR_BACK_ID, WR_BACK_RESP, RD_BACK_ID, RD_DATA_RESP} !== 12'h0 || RD_DATA !== 32'h0) begin
            n_fail++; $display("FAIL reset_payload: got %h/%h required 0",
                               {WR_BACK_ID, WR_BACK_RESP, RD_BACK_ID, RD_DATA_RESP}, RD_DATA);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        #1;
        n_checks++;
        if (WR_ADDR_READY !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b required 0", WR_ADDR_READY); end
        @(posedge clk); #1;
        n_checks++;
        if ({WR_ADDR_READY, RD_ADDR_READY, WR_DATA_READY} !== 3'b110) begin
            n_fail++; $display("FAIL ready_after_release: got %b required 110", {WR_ADDR_READY, RD_ADDR_READY, WR_DATA_READY});
        end
    endtask

    task automatic test_write_read();
        logic [3:0] id; logic [1:0] resp;
        aw_send(4'h5, 32'h10, 8'd3);
        for (int i = 0; i < 4; i++) w_send(32'hA0 + 32'(i), 4'hF, i == 3);
        b_recv(id, resp);
        n_checks++;
        if (id !== 4'h5 || resp !== 2'b00) begin n_fail++; $display("FAIL wr_bresp: got id=%h resp=%b required 5/00", id, resp); end
        ar_send(4'h5, 32'h10, 8'd3);
        n_checks++;
        if (RD_DATA_VALID !== 1'b0) begin n_fail++; $display("FAIL rd_latency_n: got %b required 0", RD_DATA_VALID); end
        @(posedge clk); #1;
        n_checks++;
        if (RD_DATA_VALID !== 1'b0) begin n_fail++; $display("FAIL rd_latency_n1: got %b required 0", RD_DATA_VALID); end
        @(posedge clk); #1;
        n_checks++;
        if (RD_DATA_VALID !== 1'b1) begin n_fail++; $display("FAIL rd_latency_n2: got %b required 1", RD_DATA_VALID); end
        r_collect(3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (r_data_q[i] !== 32'hA0 + 32'(i) || r_last_q[i] !== (i == 3)) begin
                n_fail++; $display("FAIL rd_beat%0d: got %h last=%b required %h last=%b",
                                   i, r_data_q[i], r_last_q[i], 32'hA0 + 32'(i), i == 3);
            end
        end
        n_checks++;
        if (r_id_q !== 4'h5 || RD_DATA_RESP !== 2'b00) begin n_fail++; $display("FAIL rd_id: got %h/%b required 5/00", r_id_q, RD_DATA_RESP); end
        n_checks++;
        if (RD_DATA_VALID !== 1'b0 || RD_ADDR_READY !== 1'b1) begin
            n_fail++; $display("FAIL rd_end: got valid=%b arready=%b required 0/1", RD_DATA_VALID, RD_ADDR_READY);
        end
    endtask

    task automatic test_strobe();
        logic [3:0] id; logic [1:0] resp;
        aw_send(4'h1, 32'h40, 8'd0);
        w_send(32'h1122_3344, 4'hF, 1'b1);
        b_recv(id, resp);
        aw_send(4'h2, 32'h40, 8'd0);
        w_send(32'hFFFF_FFFF, 4'b0101, 1'b1);
        b_recv(id, resp);
        n_checks++;
        if (id !== 4'h2 || resp !== 2'b00) begin n_fail++; $display("FAIL strb_bresp: got %h/%b required 2/00", id, resp); end
        ar_send(4'h3, 32'h40, 8'd0);
        r_collect(0, 1'b0);
        n_checks++;
        if (r_data_q[0] !== 32'h11FF_33FF || r_last_q[0] !== 1'b1 || r_id_q !== 4'h3) begin
            n_fail++; $display("FAIL strb_read: got %h last=%b id=%h required 11ff33ff/1/3", r_data_q[0], r_last_q[0], r_id_q);
        end
    endtask

    task automatic test_last_errors();
        logic [3:0] id; logic [1:0] resp;
        logic [31:0] exp [6];
        aw_send(4'h6, 32'h80, 8'd3);
        w_send(32'hE0, 4'hF, 1'b0);
        w_send(32'hE1, 4'hF, 1'b1);
        b_recv(id, resp);
        n_checks++;
        if (id !== 4'h6 || resp !== 2'b10) begin n_fail++; $display("FAIL early_last: got %h/%b required 6/10", id, resp); end
        aw_send(4'h7, 32'hC0, 8'd5);
        for (int i = 0; i < 6; i++) w_send(32'h5000 + 32'(i), 4'hF, i == 5);
        b_recv(id, resp);
        n_checks++;
        if (resp !== 2'b00) begin n_fail++; $display("FAIL prefill_resp: got %b required 00", resp); end
        aw_send(4'h8, 32'hC0, 8'd3);
        for (int i = 0; i < 6; i++) w_send(32'hB0 + 32'(i), 4'hF, i == 5);
        b_recv(id, resp);
        n_checks++;
        if (id !== 4'h8 || resp !== 2'b10) begin n_fail++; $display("FAIL late_last: got %h/%b required 8/10", id, resp); end
        exp = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'h5004, 32'h5005};
        ar_send(4'h9, 32'hC0, 8'd5);
        r_collect(5, 1'b0);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (r_data_q[i] !== exp[i]) begin n_fail++; $display("FAIL overrun_word%0d: got %h required %h", i, r_data_q[i], exp[i]); end
        end
        ar_send(4'h9, 32'h80, 8'd1);
        r_collect(1, 1'b0);
        n_checks++;
        if (r_data_q[0] !== 32'hE0 || r_data_q[1] !== 32'hE1) begin
            n_fail++; $display("FAIL early_words: got %h %h required e0 e1", r_data_q[0], r_data_q[1]);
        end
    endtask

    task automatic test_stall();
        logic [3:0] id; logic [1:0] resp;
        aw_send(4'hA, 32'h100, 8'd7);
        for (int i = 0; i < 8; i++) w_send(32'hC0 + 32'(i), 4'hF, i == 7);
        b_recv(id, resp);
        ar_send(4'hB, 32'h100, 8'd7);
        r_collect(7, 1'b1);
        n_checks++;
        if (r_beats !== 8 || r_hold_err !== 0) begin
            n_fail++; $display("FAIL stall_flow: got beats=%0d holderr=%0d required 8/0", r_beats, r_hold_err);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (r_data_q[i] !== 32'hC0 + 32'(i) || r_last_q[i] !== (i == 7)) begin
                n_fail++; $display("FAIL stall_beat%0d: got %h last=%b required %h", i, r_data_q[i], r_last_q[i], 32'hC0 + 32'(i));
            end
        end
    endtask

    task automatic test_wrap_and_collision();
        logic [3:0] id; logic [1:0] resp;
        aw_send(4'h1, 32'hFFC, 8'd1);
        w_send(32'hDEAD_0000, 4'hF, 1'b0);
        w_send(32'hDEAD_0001, 4'hF, 1'b1);
        b_recv(id, resp);
        ar_send(4'h2, 32'hFFC, 8'd1);
        r_collect(1, 1'b0);
        n_checks++;
        if (r_data_q[0] !== 32'hDEAD_0000 || r_data_q[1] !== 32'hDEAD_0001) begin
            n_fail++; $display("FAIL wrap_read: got %h %h required dead0000 dead0001", r_data_q[0], r_data_q[1]);
        end
        ar_send(4'h3, 32'h0, 8'd0);
        r_collect(0, 1'b0);
        n_checks++;
        if (r_data_q[0] !== 32'hDEAD_0001) begin n_fail++; $display("FAIL wrap_word0: got %h required dead0001", r_data_q[0]); end
        aw_send(4'h4, 32'h190, 8'd0);
        w_send(32'hAAAA_0000, 4'hF, 1'b1);
        b_recv(id, resp);
        aw_send(4'h4, 32'h190, 8'd0);
        ar_send(4'h5, 32'h190, 8'd0);
        // W beat lands on the same edge as the RAM read of that word
        WR_DATA = 32'h5555_5555; WR_DATA_STRB = 4'hF; WR_DATA_LAST = 1'b1; WR_DATA_VALID = 1'b1;
        @(posedge clk); #1;
        WR_DATA_VALID = 1'b0; WR_DATA_LAST = 1'b0;
        r_collect(0, 1'b0);
        n_checks++;
        if (r_data_q[0] !== 32'hAAAA_0000) begin n_fail++; $display("FAIL collide_old: got %h required aaaa0000", r_data_q[0]); end
        b_recv(id, resp);
        n_checks++;
        if (id !== 4'h4 || resp !== 2'b00) begin n_fail++; $display("FAIL collide_bresp: got %h/%b required 4/00", id, resp); end
        ar_send(4'h6, 32'h190, 8'd0);
        r_collect(0, 1'b0);
        n_checks++;
        if (r_data_q[0] !== 32'h5555_5555) begin n_fail++; $display("FAIL collide_new: got %h required 55555555", r_data_q[0]); end
    endtask

    task automatic test_reset_mid();
        logic [5:0] ctrl;
        aw_send(4'hC, 32'h200, 8'd3);
        w_send(32'h77, 4'hF, 1'b0);
        ar_send(4'hD, 32'h100, 8'd7);
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (RD_DATA_VALID !== 1'b1 || WR_DATA_READY !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: got rvalid=%b wready=%b required 1/1", RD_DATA_VALID, WR_DATA_READY);
        end
        #3 rstn = 1'b0;
        #1;
        ctrl = {WR_ADDR_READY, WR_DATA_READY, WR_BACK_VALID, RD_ADDR_READY, RD_DATA_VALID, RD_DATA_LAST};
        n_checks++;
        if (ctrl !== 6'b0) begin n_fail++; $display("FAIL mid_async: got %b required 000000", ctrl); end
        idle_inputs();
        @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({WR_ADDR_READY, RD_ADDR_READY, WR_DATA_READY} !== 3'b110) begin
            n_fail++; $display("FAIL mid_release: got %b required 110", {WR_ADDR_READY, RD_ADDR_READY, WR_DATA_READY});
        end
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (WR_BACK_VALID !== 1'b0 || RD_DATA_VALID !== 1'b0) begin
            n_fail++; $display("FAIL mid_no_resp: got b=%b r=%b required 0/0", WR_BACK_VALID, RD_DATA_VALID);
        end
        ar_send(4'hE, 32'h200, 8'd0);
        r_collect(0, 1'b0);
        n_checks++;
        if (r_data_q[0] !== 32'h77 || r_id_q !== 4'hE) begin
            n_fail++; $display("FAIL mid_kept: got %h id=%h required 77/e", r_data_q[0], r_id_q);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_last_errors();
        test_stall();
        test_wrap_and_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
